// File: rtl/servant_rst_seq.sv
// Reset sequencer: waits for (synchronised) PLL lock, stretches reset,
// then releases each reset domain in turn, bit 0 first.
module servant_rst_seq #(
   parameter int    NUM_RST     = 2,
   parameter int    STRETCH     = 16,
   parameter int    STAGGER     = 4,
   parameter int    SYNC_STAGES = 2,
   parameter string PLL         = "NONE"
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_locked,
   input  logic               i_sw_rst,
   output logic [NUM_RST-1:0] o_rst,
   output logic               o_ready
);

   localparam int LAST = (NUM_RST - 1) * STAGGER;
   localparam int CMAX = (STRETCH > LAST + 1) ? STRETCH : LAST + 1;
   localparam int CW   = $clog2(CMAX + 1);

   localparam logic [CW-1:0] STR_END = CW'(STRETCH - 1);
   localparam logic [CW-1:0] REL_END = CW'(LAST);
   localparam bit            USE_PLL = (PLL != "NONE");

   typedef enum logic [1:0] {
      S_WAIT_LOCK,
      S_STRETCH,
      S_RELEASE,
      S_RUN
   } state_t;

   state_t                 state;
   logic [CW-1:0]          cnt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   lock_in;
   logic                   lock_s;

   // Without a PLL the tied-high input makes this the reset-release synchroniser
   assign lock_in = USE_PLL ? i_locked : 1'b1;
   assign lock_s  = sync_q[SYNC_STAGES-1];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], lock_in};
      end
   end

   // Bits whose release falls on counter value c
   function automatic logic [NUM_RST-1:0] rel_mask(input logic [CW-1:0] c);
      logic [NUM_RST-1:0] m;
      m = '0;
      for (int k = 0; k < NUM_RST; k++) begin
         m[k] = (k * STAGGER == int'(c));
      end
      return m;
   endfunction

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= S_WAIT_LOCK;
         cnt     <= '0;
         o_rst   <= '1;
         o_ready <= 1'b0;
      end else begin
         unique case (state)
            S_WAIT_LOCK: begin
               if (lock_s) begin
                  state <= S_STRETCH;
                  cnt   <= '0;
               end
            end
            S_STRETCH: begin
               if (!lock_s) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
               end else if (i_sw_rst) begin
                  cnt <= '0;
               end else if (cnt == STR_END) begin
                  state <= S_RELEASE;
                  cnt   <= '0;
                  o_rst <= o_rst & ~rel_mask('0);
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               if (!lock_s) begin
                  state <= S_WAIT_LOCK;
                  cnt   <= '0;
                  o_rst <= '1;
               end else if (i_sw_rst) begin
                  state <= S_STRETCH;
                  cnt   <= '0;
                  o_rst <= '1;
               end else if (cnt == REL_END) begin
                  state   <= S_RUN;
                  o_ready <= 1'b1;
               end else begin
                  cnt   <= cnt + 1'b1;
                  o_rst <= o_rst & ~rel_mask(cnt + 1'b1);
               end
            end
            S_RUN: begin
               if (!lock_s) begin
                  state   <= S_WAIT_LOCK;
                  cnt     <= '0;
                  o_rst   <= '1;
                  o_ready <= 1'b0;
               end else if (i_sw_rst) begin
                  state   <= S_STRETCH;
                  cnt     <= '0;
                  o_rst   <= '1;
                  o_ready <= 1'b0;
               end
            end
            default: begin
               state   <= S_WAIT_LOCK;
               cnt     <= '0;
               o_rst   <= '1;
               o_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_servant_rst_seq.sv
// Directed bench for servant_rst_seq: edge-indexed expectations queued
// and checked as the run reaches each edge.
module tb_servant_rst_seq;

   logic       clk;
   logic       rst0, rst1, rst2, rst3;
   logic       locked0, locked1, locked2, locked3;
   logic       sw0, sw1, sw2, sw3;
   logic [1:0] r0, r1;
   logic [3:0] r2;
   logic [0:0] r3;
   logic       rdy0, rdy1, rdy2, rdy3;

   int tests = 0;
   int fails = 0;
   int edge_n = 0;

   typedef struct {
      int         sel;
      int         edge_n;
      logic [8:0] val;
      string      tag;
   } exp_t;

   exp_t sb[$];

   servant_rst_seq u0 (
      .i_clk(clk), .i_rst(rst0), .i_locked(locked0), .i_sw_rst(sw0),
      .o_rst(r0), .o_ready(rdy0));

   servant_rst_seq #(.PLL("ICE40")) u1 (
      .i_clk(clk), .i_rst(rst1), .i_locked(locked1), .i_sw_rst(sw1),
      .o_rst(r1), .o_ready(rdy1));

   servant_rst_seq #(.NUM_RST(4), .STAGGER(0)) u2 (
      .i_clk(clk), .i_rst(rst2), .i_locked(locked2), .i_sw_rst(sw2),
      .o_rst(r2), .o_ready(rdy2));

   servant_rst_seq #(.NUM_RST(1), .STRETCH(1)) u3 (
      .i_clk(clk), .i_rst(rst3), .i_locked(locked3), .i_sw_rst(sw3),
      .o_rst(r3), .o_ready(rdy3));

   always #5 clk = ~clk;

   function automatic logic [8:0] obs(input int sel);
      case (sel)
         0:       return {rdy0, 6'd0, r0};
         1:       return {rdy1, 6'd0, r1};
         2:       return {rdy2, 4'd0, r2};
         3:       return {rdy3, 7'd0, r3};
         default: return 9'h1ff;
      endcase
   endfunction

   task automatic check(input string tag, input logic [8:0] o,
                        input logic [8:0] x);
      tests++;
      assert (o === x) else begin
         fails++;
         $error("FAIL %s: observed rdy/rst=%h expected %h", tag, o, x);
      end
   endtask

   task automatic push(input int sel, input int e, input logic [7:0] r,
                       input logic rd, input string tag);
      exp_t x;
      x.sel    = sel;
      x.edge_n = e;
      x.val    = {rd, r};
      x.tag    = $sformatf("%s@%0d", tag, e);
      sb.push_back(x);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic run(input int n);
      exp_t x;
      repeat (n) begin
         step();
         while (sb.size() > 0 && sb[0].edge_n == edge_n) begin
            x = sb.pop_front();
            check(x.tag, obs(x.sel), x.val);
         end
      end
      while (sb.size() > 0) begin
         x = sb.pop_front();
         tests++;
         fails++;
         $display("FAIL %s: edge not reached, at %0d", x.tag, edge_n);
      end
   endtask

   initial begin
      clk = 1'b0;
      {rst0, rst1, rst2, rst3} = 4'hf;
      {locked0, locked1, locked2, locked3} = 4'h0;
      {sw0, sw1, sw2, sw3} = 4'h0;

      #2;
      check("reset_noclk", obs(0), 9'h003);
      step();
      step();
      step();
      check("reset_u0", obs(0), 9'h003);
      check("reset_u1", obs(1), 9'h003);
      check("reset_u2", obs(2), 9'h00f);
      check("reset_u3", obs(3), 9'h001);

      // default config, PLL ignored
      rst0 = 1'b0;
      edge_n = 0;
      push(0, 1, 8'h3, 1'b0, "def_early");
      push(0, 18, 8'h3, 1'b0, "def_held");
      push(0, 19, 8'h2, 1'b0, "def_bit0");
      push(0, 22, 8'h2, 1'b0, "def_b1held");
      push(0, 23, 8'h0, 1'b0, "def_bit1");
      push(0, 24, 8'h0, 1'b1, "def_ready");
      run(26);

      // soft reset from RUN
      sw0 = 1'b1;
      edge_n = 0;
      push(0, 1, 8'h3, 1'b0, "sw_set");
      run(1);
      sw0 = 1'b0;
      push(0, 16, 8'h3, 1'b0, "sw_held");
      push(0, 17, 8'h2, 1'b0, "sw_bit0");
      push(0, 20, 8'h2, 1'b0, "sw_b1held");
      push(0, 21, 8'h0, 1'b0, "sw_bit1");
      push(0, 22, 8'h0, 1'b1, "sw_ready");
      run(24);

      // async reset between bit0 and bit1 release
      sw0 = 1'b1;
      edge_n = 0;
      run(1);
      sw0 = 1'b0;
      push(0, 17, 8'h2, 1'b0, "mid_bit0");
      run(18);
      #1;
      rst0 = 1'b1;
      #1;
      check("mid_async", obs(0), 9'h003);
      #1;
      rst0 = 1'b0;
      edge_n = 0;
      push(0, 18, 8'h3, 1'b0, "re_held");
      push(0, 19, 8'h2, 1'b0, "re_bit0");
      push(0, 23, 8'h0, 1'b0, "re_bit1");
      push(0, 24, 8'h0, 1'b1, "re_ready");
      run(25);

      // PLL variant: wait for lock
      rst1 = 1'b0;
      edge_n = 0;
      push(1, 50, 8'h3, 1'b0, "pll_nolock");
      run(50);
      locked1 = 1'b1;
      edge_n = 0;
      push(1, 18, 8'h3, 1'b0, "pll_held");
      push(1, 19, 8'h2, 1'b0, "pll_bit0");
      push(1, 23, 8'h0, 1'b0, "pll_bit1");
      push(1, 24, 8'h0, 1'b1, "pll_ready");
      run(25);

      // one-cycle lock drop in RUN
      locked1 = 1'b0;
      edge_n = 0;
      push(1, 1, 8'h0, 1'b1, "drop_e1");
      run(1);
      locked1 = 1'b1;
      push(1, 2, 8'h0, 1'b1, "drop_e2");
      push(1, 3, 8'h3, 1'b0, "drop_set");
      push(1, 19, 8'h3, 1'b0, "drop_held");
      push(1, 20, 8'h2, 1'b0, "drop_bit0");
      push(1, 24, 8'h0, 1'b0, "drop_bit1");
      push(1, 25, 8'h0, 1'b1, "drop_ready");
      run(26);

      // lock loss and soft reset on the same edge
      locked1 = 1'b0;
      edge_n = 0;
      run(1);
      locked1 = 1'b1;
      run(1);
      sw1 = 1'b1;
      push(1, 3, 8'h3, 1'b0, "prio_set");
      run(1);
      sw1 = 1'b0;
      push(1, 19, 8'h3, 1'b0, "prio_held");
      push(1, 20, 8'h2, 1'b0, "prio_bit0");
      push(1, 25, 8'h0, 1'b1, "prio_ready");
      run(26);

      // four domains, no stagger
      rst2 = 1'b0;
      edge_n = 0;
      push(2, 18, 8'hf, 1'b0, "ns_held");
      push(2, 19, 8'h0, 1'b0, "ns_all");
      push(2, 20, 8'h0, 1'b1, "ns_ready");
      run(21);

      // single domain, minimum stretch
      rst3 = 1'b0;
      edge_n = 0;
      push(3, 3, 8'h1, 1'b0, "one_held");
      push(3, 4, 8'h0, 1'b0, "one_bit0");
      push(3, 5, 8'h0, 1'b1, "one_ready");
      run(6);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
